// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } pq_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Synchronous FIFO of {pc, inst} entries; head is read combinationally from
// the registered array so a pushed word is visible the cycle after its push.
module pq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  pq_entry_t              i_data,
  output pq_entry_t              o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  pq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: runs a fetch PC ahead of IF, buffers returned
// words with their PCs, and flushes on a taken branch or jump.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   Redirect,
  input  logic [31:0]            RedirectPC,
  input  logic                   Stall,
  output logic                   IMemRd,
  output logic [31:0]            IMemAddr,
  input  logic [31:0]            IMemData,
  output logic                   InstValid,
  output logic [31:0]            Inst,
  output logic [31:0]            InstPC,
  output logic [31:0]            InstPC4,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int             CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    LP_DEPTH = (CW + 1)'(DEPTH);

  logic [INST_W-1:0] r_fpc;
  logic [INST_W-1:0] r_ipc;
  logic              r_inflight;

  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occupied;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  pq_entry_t         w_push_entry;
  pq_entry_t         w_head;

  // An in-flight read already owns a slot, so it counts against the credit.
  assign w_occupied = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue    = Resetn & ~Redirect & (w_occupied < LP_DEPTH);
  assign w_valid    = (w_count != '0);
  assign w_push     = r_inflight & ~Redirect;
  assign w_pop      = w_valid & ~Stall & ~Redirect;

  assign w_push_entry.pc   = r_ipc;
  assign w_push_entry.inst = IMemData;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_fpc      <= RESET_PC;
      r_ipc      <= '0;
      r_inflight <= 1'b0;
    end else if (Redirect) begin
      r_fpc      <= RedirectPC;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_fpc      <= r_fpc + PC_STEP;
      r_ipc      <= r_fpc;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  pq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (Resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (Redirect),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign IMemRd    = w_issue;
  assign IMemAddr  = r_fpc;
  assign InstValid = w_valid;
  assign Inst      = w_head.inst;
  assign InstPC    = w_head.pc;
  assign InstPC4   = w_head.pc + PC_STEP;
  assign Count     = w_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: a queue-based reference model tracks the
// expected head, occupancy and fetch address under directed and random traffic.
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Redirect = 1'b0;
  logic [31:0]   RedirectPC = '0;
  logic          Stall = 1'b0;
  logic [31:0]   IMemData = '0;
  logic          IMemRd;
  logic [31:0]   IMemAddr;
  logic          InstValid;
  logic [31:0]   Inst;
  logic [31:0]   InstPC;
  logic [31:0]   InstPC4;
  logic [CW-1:0] Count;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Resetn(Resetn), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Stall(Stall), .IMemRd(IMemRd), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .InstValid(InstValid), .Inst(Inst), .InstPC(InstPC), .InstPC4(InstPC4),
    .Count(Count)
  );

  always #5 Clock = ~Clock;

  // Synchronous instruction memory: word at addr is addr+100, one cycle later.
  always @(posedge Clock) IMemData <= IMemRd ? IMemAddr + 32'd100 : 32'hBAD0_BAD0;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of buffered PCs plus one pending memory read.
  logic [31:0] m_pc[$];
  bit          m_pend;
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;

  bit          e_valid, e_rd;
  logic [31:0] e_pc, e_addr;
  int          e_count;

  task automatic model_reset();
    m_pc.delete();
    m_pend = 1'b0;
    m_ipc  = '0;
    m_fpc  = RESET_PC;
  endtask

  task automatic drive(input bit r, input logic [31:0] rpc, input bit s);
    Redirect   = r;
    RedirectPC = rpc;
    Stall      = s;
    #1;
    e_valid = (m_pc.size() != 0);
    e_pc    = e_valid ? m_pc[0] : 32'h0;
    e_count = m_pc.size();
    e_addr  = m_fpc;
    e_rd    = (Resetn === 1'b1) && !r && (m_pc.size() + int'(m_pend) < DEPTH);
  endtask

  task automatic advance();
    int sz;
    sz = m_pc.size();
    if (Redirect) begin
      m_pc.delete();
      m_pend = 1'b0;
      m_fpc  = RedirectPC;
    end else begin
      if (sz > 0 && !Stall) void'(m_pc.pop_front());
      if (m_pend) m_pc.push_back(m_ipc);
      if (e_rd) begin
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if ({IMemRd, InstValid, Count} !== '0 || IMemAddr !== RESET_PC)
      begin fails++; $display("FAIL reset_ctrl: rd=%0b valid=%0b count=%0d addr=%08h, required 0 0 0 %08h", IMemRd, InstValid, Count, IMemAddr, RESET_PC); end
    tests++;
    if (Inst !== 32'h0 || InstPC !== 32'h0 || InstPC4 !== 32'h4)
      begin fails++; $display("FAIL reset_head: inst=%08h pc=%08h pc4=%08h, required 0 0 4", Inst, InstPC, InstPC4); end
    model_reset();
    Resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      tests++;
      if (IMemAddr !== e_addr || IMemRd !== e_rd)
        begin fails++; $display("FAIL start_issue c%0d: addr=%08h rd=%0b, required %08h %0b", c, IMemAddr, IMemRd, e_addr, e_rd); end
      if (c < 3) begin
        tests++;
        if (IMemAddr !== 32'(4 * c))
          begin fails++; $display("FAIL start_addr c%0d: %08h, required %08h", c, IMemAddr, 32'(4 * c)); end
      end
      if (c == 0) begin
        tests++;
        if (IMemRd !== 1'b1) begin fails++; $display("FAIL first_rd: %0b, required 1", IMemRd); end
      end
      if (c == 1) begin
        tests++;
        if (InstValid !== 1'b0) begin fails++; $display("FAIL early_valid: %0b, required 0", InstValid); end
      end
      if (c == 2) begin
        tests++;
        if (InstValid !== 1'b1 || Inst !== 32'd100 || InstPC !== 32'h0 || InstPC4 !== 32'h4)
          begin fails++; $display("FAIL first_inst: v=%0b inst=%0d pc=%08h pc4=%08h, required 1 100 0 4", InstValid, Inst, InstPC, InstPC4); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc;
    hold_pc = '0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (k == 0) hold_pc = e_pc;
      tests++;
      if (Count !== CW'(e_count) || IMemRd !== e_rd || InstValid !== e_valid)
        begin fails++; $display("FAIL stall_state k%0d: count=%0d rd=%0b v=%0b, required %0d %0b %0b", k, Count, IMemRd, InstValid, e_count, e_rd, e_valid); end
      tests++;
      if (InstValid !== 1'b1 || InstPC !== hold_pc)
        begin fails++; $display("FAIL stall_hold k%0d: pc=%08h, required %08h", k, InstPC, hold_pc); end
      if (k == 5) begin
        tests++;
        if (Count !== CW'(DEPTH) || IMemRd !== 1'b0)
          begin fails++; $display("FAIL stall_full: count=%0d rd=%0b, required %0d 0", Count, IMemRd, DEPTH); end
      end
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      tests++;
      if (InstValid !== 1'b1 || InstPC !== hold_pc + 32'(4 * k) || Inst !== hold_pc + 32'(4 * k) + 32'd100)
        begin fails++; $display("FAIL drain k%0d: v=%0b pc=%08h inst=%08h, required pc %08h", k, InstValid, InstPC, Inst, hold_pc + 32'(4 * k)); end
      advance();
    end
  endtask

  task automatic test_redirect();
    int n;
    settle(3);
    for (n = 0; n < 12; n++) begin
      if (m_pc.size() == 3 && m_pend) break;
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end
    tests++;
    if (n == 12) begin fails++; $display("FAIL redirect_setup: 3 queued + inflight not reached, count=%0d", Count); end
    drive(1'b1, 32'h40, 1'b0);
    tests++;
    if (IMemRd !== 1'b0) begin fails++; $display("FAIL redirect_rd: %0b, required 0", IMemRd); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (Count !== '0 || InstValid !== 1'b0 || IMemAddr !== 32'h40 || IMemRd !== 1'b1)
      begin fails++; $display("FAIL redirect_r1: count=%0d v=%0b addr=%08h rd=%0b, required 0 0 00000040 1", Count, InstValid, IMemAddr, IMemRd); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (InstValid !== 1'b0) begin fails++; $display("FAIL redirect_r2: v=%0b pc=%08h, required 0", InstValid, InstPC); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (InstValid !== 1'b1 || InstPC !== 32'h40 || Inst !== 32'h40 + 32'd100 || InstPC4 !== 32'h44)
      begin fails++; $display("FAIL redirect_r3: v=%0b pc=%08h inst=%08h pc4=%08h, required 1 00000040 000000a4 00000044", InstValid, InstPC, Inst, InstPC4); end
    advance();
  endtask

  task automatic test_redirect_stall();
    int  n;
    bit  seen;
    settle(3);
    for (n = 0; n < 12; n++) begin
      if (m_pc.size() == 2) break;
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end
    tests++;
    if (n == 12) begin fails++; $display("FAIL rs_setup: count 2 not reached, count=%0d", Count); end
    drive(1'b1, 32'h200, 1'b1);
    advance();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (InstValid === 1'b1 && !seen) begin
        seen = 1'b1;
        tests++;
        if (InstPC !== 32'h200) begin fails++; $display("FAIL rs_first: pc=%08h, required 00000200", InstPC); end
      end
      tests++;
      if (InstValid !== e_valid || (e_valid && InstPC !== e_pc))
        begin fails++; $display("FAIL rs_stream k%0d: v=%0b pc=%08h, required %0b %08h", k, InstValid, InstPC, e_valid, e_pc); end
      advance();
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rs_timeout: no instruction delivered after flush"); end
  endtask

  task automatic test_pushpop_full();
    int          n;
    logic [31:0] prev;
    settle(3);
    for (n = 0; n < 12; n++) begin
      if (m_pc.size() == DEPTH - 1 && m_pend) break;
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end
    tests++;
    if (n == 12) begin fails++; $display("FAIL pp_setup: near-full with inflight not reached, count=%0d", Count); end
    drive(1'b0, 32'h0, 1'b0);
    prev = e_pc;
    tests++;
    if (Count !== CW'(DEPTH - 1)) begin fails++; $display("FAIL pp_before: count=%0d, required %0d", Count, DEPTH - 1); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (Count !== CW'(DEPTH - 1) || InstPC !== prev + 32'd4)
      begin fails++; $display("FAIL pp_after: count=%0d pc=%08h, required %0d %08h", Count, InstPC, DEPTH - 1, prev + 32'd4); end
    advance();
    for (n = 0; n < 12; n++) begin
      if (m_pc.size() == DEPTH) break;
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end
    drive(1'b0, 32'h0, 1'b0);
    prev = e_pc;
    tests++;
    if (Count !== CW'(DEPTH) || IMemRd !== 1'b0) begin fails++; $display("FAIL pp_full: count=%0d rd=%0b, required %0d 0", Count, IMemRd, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) drive(1'b0, 32'h0, 1'b0);
      tests++;
      if (InstValid !== 1'b1 || InstPC !== prev + 32'(4 * k) || Count !== CW'(e_count))
        begin fails++; $display("FAIL pp_order k%0d: pc=%08h count=%0d, required %08h %0d", k, InstPC, Count, prev + 32'(4 * k), e_count); end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    int          got;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    drive(1'b1, 32'hFFFF_FFF8, 1'b0);
    advance();
    got = 0;
    for (int k = 0; k < 10 && got < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (InstValid === 1'b1) begin
        tests++;
        if (InstPC !== wexp[got] || Inst !== wexp[got] + 32'd100)
          begin fails++; $display("FAIL wrap%0d: pc=%08h inst=%08h, required %08h %08h", got, InstPC, Inst, wexp[got], wexp[got] + 32'd100); end
        got++;
      end
      advance();
    end
    tests++;
    if (got != 3) begin fails++; $display("FAIL wrap_timeout: %0d of 3 delivered", got); end
  endtask

  task automatic test_random();
    bit          r, s;
    logic [31:0] rpc;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom % 100) < 6;
      s = ($urandom % 100) < 30;
      case ($urandom % 3)
        0:       rpc = $urandom & 32'hFFFF_FFFC;
        1:       rpc = 32'hFFFF_FFF0;
        default: rpc = $urandom;
      endcase
      drive(r, rpc, s);
      tests++;
      if (InstValid !== e_valid || Count !== CW'(e_count) || IMemAddr !== e_addr || IMemRd !== e_rd)
        begin fails++; $display("FAIL rand_ctrl k%0d: v=%0b cnt=%0d addr=%08h rd=%0b, required %0b %0d %08h %0b", k, InstValid, Count, IMemAddr, IMemRd, e_valid, e_count, e_addr, e_rd); end
      if (e_valid) begin
        tests++;
        if (InstPC !== e_pc || Inst !== e_pc + 32'd100 || InstPC4 !== e_pc + 32'd4)
          begin fails++; $display("FAIL rand_head k%0d: pc=%08h inst=%08h pc4=%08h, required pc %08h", k, InstPC, Inst, InstPC4, e_pc); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    settle(3);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    tests++;
    if ({IMemRd, InstValid, Count} !== '0 || IMemAddr !== RESET_PC || Inst !== 32'h0 || InstPC !== 32'h0 || InstPC4 !== 32'h4)
      begin fails++; $display("FAIL midreset: rd=%0b v=%0b cnt=%0d addr=%08h inst=%08h pc=%08h pc4=%08h, required reset values", IMemRd, InstValid, Count, IMemAddr, Inst, InstPC, InstPC4); end
    model_reset();
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (InstValid === 1'b1 && !seen) begin
        seen = 1'b1;
        tests++;
        if (InstPC !== RESET_PC) begin fails++; $display("FAIL restart_pc: %08h, required %08h", InstPC, RESET_PC); end
      end
      tests++;
      if (InstValid !== e_valid || IMemAddr !== e_addr || (e_valid && InstPC !== e_pc))
        begin fails++; $display("FAIL restart k%0d: v=%0b addr=%08h pc=%08h, required %0b %08h %08h", k, InstValid, IMemAddr, InstPC, e_valid, e_addr, e_pc); end
      advance();
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL restart_timeout: nothing delivered after reset"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_pushpop_full();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
